// File: rtl/uart_apb_pkg.sv
// -----------------------------------------------------------------------------
// uart_apb_pkg
// Shared definitions for the UART APB register front-end: register word
// indices, STATUS bit positions and the transfer FSM state encoding.
// -----------------------------------------------------------------------------
package uart_apb_pkg;

  // Register word indices (decoded from paddr)
  localparam int REG_DATA   = 0;
  localparam int REG_STATUS = 1;
  localparam int REG_CLEAR  = 2;
  localparam int REG_IRQ_EN = 3;

  // STATUS bit positions; CLEAR uses the same positions for the sticky bits
  localparam int STAT_RX_EMPTY = 0;
  localparam int STAT_TX_FULL  = 1;
  localparam int STAT_BUSY     = 2;
  localparam int STAT_TX_DROP  = 3;
  localparam int STAT_RX_UNDER = 4;
  localparam int STAT_UART_IRQ = 5;

  // IRQ_EN bit positions (only meaningful when the mask feature is built)
  localparam int IRQ_EN_UART  = 0;
  localparam int IRQ_EN_DROP  = 1;
  localparam int IRQ_EN_UNDER = 2;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } apb_state_t;

endpackage

// File: rtl/uart_apb_regs.sv
// -----------------------------------------------------------------------------
// uart_apb_regs
// APB3 slave register front-end for the UART FIFO block. Turns bus accesses
// into one-cycle push/pop strobes, returns RX bytes and status, keeps sticky
// error flags and drives a registered level interrupt.
//
// Every transfer runs IDLE -> ACCESS -> DONE. The access is accepted in IDLE
// when psel & penable are seen; the FIFO strobe is high during ACCESS and
// pready/pslverr/prdata are presented during DONE.
//
// Ports:
//   clk, rst           clock, synchronous active-low reset
//   paddr/psel/penable/pwrite/pwdata   APB request
//   prdata/pready/pslverr              APB response (valid while pready=1)
//   tx_byte, transmit  byte and push strobe to the TX FIFO
//   rx_fifo_pop        pop strobe to the RX FIFO
//   rx_byte, tx_fifo_full, rx_fifo_empty, uart_busy, uart_irq  FIFO/UART status
//   irq                registered interrupt to the core
//
// Build option: define UART_APB_IRQ_MASK_EN to add the IRQ_EN register at
// index 3 (bit0 uart_irq, bit1 tx_drop, bit2 rx_under). Without it, index 3
// is unmapped and irq is the plain OR of all three sources.
// -----------------------------------------------------------------------------
module uart_apb_regs
  import uart_apb_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] paddr,
  input  logic                  psel,
  input  logic                  penable,
  input  logic                  pwrite,
  input  logic [DATA_WIDTH-1:0] pwdata,
  output logic [DATA_WIDTH-1:0] prdata,
  output logic                  pready,
  output logic                  pslverr,
  output logic [7:0]            tx_byte,
  output logic                  transmit,
  output logic                  rx_fifo_pop,
  input  logic [7:0]            rx_byte,
  input  logic                  tx_fifo_full,
  input  logic                  rx_fifo_empty,
  input  logic                  uart_busy,
  input  logic                  uart_irq,
  output logic                  irq
);

  apb_state_t state;

  logic tx_q, pop_q, err_q;
  logic tx_drop, rx_under;
  logic start;
  logic sel_data, sel_status, sel_clear;
  logic do_tx, do_pop, set_tx_drop, set_rx_under;
  logic clr_tx_drop, clr_rx_under;
  logic acc_err;
  logic irq_src;
  logic [7:0] status_byte;
  logic [DATA_WIDTH-1:0] rd_value;

  // pwdata above the byte lane carries no meaning for this block.
  logic unused_pwdata;
  assign unused_pwdata = ^pwdata[DATA_WIDTH-1:8];

  assign start      = (state == IDLE) & psel & penable;
  assign sel_data   = (paddr == ADDR_WIDTH'(REG_DATA));
  assign sel_status = (paddr == ADDR_WIDTH'(REG_STATUS));
  assign sel_clear  = (paddr == ADDR_WIDTH'(REG_CLEAR));

  // All side effects are decided from the single cycle the access is accepted,
  // so a transfer can never produce a second strobe however long psel stays up.
  assign do_tx        = start &  pwrite & sel_data & ~tx_fifo_full;
  assign set_tx_drop  = start &  pwrite & sel_data &  tx_fifo_full;
  assign do_pop       = start & ~pwrite & sel_data & ~rx_fifo_empty;
  assign set_rx_under = start & ~pwrite & sel_data &  rx_fifo_empty;
  assign clr_tx_drop  = start &  pwrite & sel_clear & pwdata[STAT_TX_DROP];
  assign clr_rx_under = start &  pwrite & sel_clear & pwdata[STAT_RX_UNDER];

`ifdef UART_APB_IRQ_MASK_EN
  logic       sel_irq_en;
  logic [2:0] irq_en;
  assign sel_irq_en = (paddr == ADDR_WIDTH'(REG_IRQ_EN));
  assign irq_src = (uart_irq & irq_en[IRQ_EN_UART])
                 | (tx_drop  & irq_en[IRQ_EN_DROP])
                 | (rx_under & irq_en[IRQ_EN_UNDER]);
`else
  assign irq_src = uart_irq | tx_drop | rx_under;
`endif

  // Read mux and error decode for the access being accepted.
  // NOTE: every signal gets a default at the top of always_comb; a path that
  // skips an assignment would otherwise infer a latch.
  always_comb begin
    acc_err     = 1'b0;
    rd_value    = '0;
    status_byte = '0;
    status_byte[STAT_RX_EMPTY] = rx_fifo_empty;
    status_byte[STAT_TX_FULL]  = tx_fifo_full;
    status_byte[STAT_BUSY]     = uart_busy;
    status_byte[STAT_TX_DROP]  = tx_drop;
    status_byte[STAT_RX_UNDER] = rx_under;
    status_byte[STAT_UART_IRQ] = uart_irq;
    if (sel_data) begin
      acc_err = pwrite ? tx_fifo_full : rx_fifo_empty;
      // rx_byte is still the FIFO head here; the pop lands after this cycle.
      if (!pwrite && !rx_fifo_empty) rd_value[7:0] = rx_byte;
    end else if (sel_status) begin
      acc_err = pwrite;
      if (!pwrite) rd_value[7:0] = status_byte;
    end else if (sel_clear) begin
      acc_err = 1'b0;
`ifdef UART_APB_IRQ_MASK_EN
    end else if (sel_irq_en) begin
      if (!pwrite) rd_value[2:0] = irq_en;
`endif
    end else begin
      acc_err = 1'b1;
    end
  end

  // NOTE: all state below uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= IDLE;
      pready   <= 1'b0;
      pslverr  <= 1'b0;
      prdata   <= '0;
      tx_q     <= 1'b0;
      pop_q    <= 1'b0;
      err_q    <= 1'b0;
      tx_byte  <= '0;
      tx_drop  <= 1'b0;
      rx_under <= 1'b0;
      irq      <= 1'b0;
`ifdef UART_APB_IRQ_MASK_EN
      irq_en   <= '0;
`endif
    end else begin
      tx_q  <= 1'b0;
      pop_q <= 1'b0;
      // A set in the same cycle as a clear wins.
      tx_drop  <= set_tx_drop  | (tx_drop  & ~clr_tx_drop);
      rx_under <= set_rx_under | (rx_under & ~clr_rx_under);
      irq      <= irq_src;
      case (state)
        IDLE: begin
          if (start) begin
            state  <= ACCESS;
            tx_q   <= do_tx;
            pop_q  <= do_pop;
            err_q  <= acc_err;
            prdata <= rd_value;
            if (do_tx) tx_byte <= pwdata[7:0];
`ifdef UART_APB_IRQ_MASK_EN
            if (pwrite && sel_irq_en) irq_en <= pwdata[2:0];
`endif
          end
        end
        ACCESS: begin
          // Completes even if psel was dropped; no new access is accepted here.
          state   <= DONE;
          pready  <= 1'b1;
          pslverr <= err_q;
        end
        DONE: begin
          state   <= IDLE;
          pready  <= 1'b0;
          pslverr <= 1'b0;
          prdata  <= '0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Reset asserted during ACCESS suppresses the strobe in that same cycle.
  assign transmit    = tx_q  & rst;
  assign rx_fifo_pop = pop_q & rst;

endmodule

// File: tb/tb_uart_apb_regs.sv
// -----------------------------------------------------------------------------
// tb_uart_apb_regs
// Self-checking bench for uart_apb_regs: directed vector table, hand-written
// corner sequences and a randomized run against a behavioural model.
// Honours UART_APB_IRQ_MASK_EN the same way the design does.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_uart_apb_regs;

`ifdef UART_APB_IRQ_MASK_EN
  localparam bit MASK_EN = 1'b1;
`else
  localparam bit MASK_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [1:0]  paddr = '0;
  logic        psel = 1'b0, penable = 1'b0, pwrite = 1'b0;
  logic [15:0] pwdata = '0;
  logic [15:0] prdata;
  logic        pready, pslverr;
  logic [7:0]  tx_byte;
  logic        transmit, rx_fifo_pop;
  logic [7:0]  rx_byte = '0;
  logic        tx_fifo_full = 1'b0, rx_fifo_empty = 1'b0;
  logic        uart_busy = 1'b0, uart_irq = 1'b0;
  logic        irq;

  int total = 0;
  int bad   = 0;

  uart_apb_regs #(.DATA_WIDTH(16), .ADDR_WIDTH(2)) dut (
    .clk(clk), .rst(rst),
    .paddr(paddr), .psel(psel), .penable(penable), .pwrite(pwrite),
    .pwdata(pwdata), .prdata(prdata), .pready(pready), .pslverr(pslverr),
    .tx_byte(tx_byte), .transmit(transmit), .rx_fifo_pop(rx_fifo_pop),
    .rx_byte(rx_byte), .tx_fifo_full(tx_fifo_full), .rx_fifo_empty(rx_fifo_empty),
    .uart_busy(uart_busy), .uart_irq(uart_irq), .irq(irq)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation still running at %0t, required done", $time);
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", name, got, exp);
    end
  endtask

  // Result of one observed transfer. lat = cycle (0 = cycle the access is
  // first presented with penable) in which pready is seen; -1 if never.
  typedef struct {
    logic [15:0] rd;
    logic        err;
    int          lat;
    int          ntx;
    int          npop;
    logic [7:0]  txb;
    int          scyc;
  } res_t;

  task automatic apb_xfer(input logic wr, input logic [1:0] a, input logic [15:0] wd,
                          input bit fc, input bit drop, output res_t r);
    bit seen;
    seen = 1'b0;
    r = '{rd: '0, err: 1'b0, lat: -1, ntx: 0, npop: 0, txb: '0, scyc: -1};
    @(posedge clk); #1;
    psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = a; pwdata = wd;
    @(posedge clk); #1;
    penable = 1'b1;
    if (fc) force dut.clr_rx_under = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (transmit)    begin r.ntx++;  r.txb = tx_byte; r.scyc = c; end
      if (rx_fifo_pop) begin r.npop++; r.scyc = c; end
      if (pready && !seen) begin
        seen = 1'b1; r.lat = c; r.rd = prdata; r.err = pslverr;
        @(posedge clk); #1;
        psel = 1'b0; penable = 1'b0;
      end else if (c == 0 && (fc || drop)) begin
        @(posedge clk); #1;
        if (fc) release dut.clr_rx_under;
        if (drop) begin psel = 1'b0; penable = 1'b0; end
      end
    end
    psel = 1'b0; penable = 1'b0;
  endtask

  typedef struct {
    logic        wr;   logic [1:0] a;  logic [15:0] wd;
    logic        full; logic empty; logic busy; logic uirq; logic [7:0] rxb;
    logic [15:0] rd;   logic err;   int ntx;    int npop;   logic [7:0] txb;
    logic        irq;
  } vec_t;

  vec_t tbl[14];
  res_t r;
  logic [7:0] exp_txb;

  // Behavioural model state for the random run
  logic       m_drop, m_under;
  logic [2:0] m_en;
  logic       wr;
  logic [1:0] a;
  logic [15:0] wd, e_rd;
  logic       e_err, e_irq;
  int         e_tx, e_pop;

  initial begin
    // irq column is the unmasked expectation; with the mask built, IRQ_EN=0.
    tbl[0]  = '{1'b1, 2'd0, 16'h00A5, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 16'h0000, 1'b0, 1, 0, 8'hA5, 1'b0};
    tbl[1]  = '{1'b0, 2'd0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 8'h3C, 16'h003C, 1'b0, 0, 1, 8'h00, 1'b0};
    tbl[2]  = '{1'b1, 2'd0, 16'h0011, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 16'h0000, 1'b1, 0, 0, 8'h00, 1'b1};
    tbl[3]  = '{1'b0, 2'd1, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 16'h000A, 1'b0, 0, 0, 8'h00, 1'b1};
    tbl[4]  = '{1'b1, 2'd2, 16'h0008, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 16'h0000, 1'b0, 0, 0, 8'h00, 1'b0};
    tbl[5]  = '{1'b0, 2'd1, 16'h0000, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 16'h0005, 1'b0, 0, 0, 8'h00, 1'b0};
    tbl[6]  = '{1'b0, 2'd0, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0, 8'h77, 16'h0000, 1'b1, 0, 0, 8'h00, 1'b1};
    tbl[7]  = '{1'b0, 2'd1, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b1, 8'h00, 16'h0031, 1'b0, 0, 0, 8'h00, 1'b1};
    tbl[8]  = '{1'b1, 2'd1, 16'h00FF, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 16'h0000, 1'b1, 0, 0, 8'h00, 1'b1};
    tbl[9]  = '{1'b0, 2'd2, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 16'h0000, 1'b0, 0, 0, 8'h00, 1'b1};
    tbl[10] = '{1'b1, 2'd2, 16'h0010, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 16'h0000, 1'b0, 0, 0, 8'h00, 1'b0};
    tbl[11] = '{1'b0, 2'd1, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 16'h0000, 1'b0, 0, 0, 8'h00, 1'b0};
`ifdef UART_APB_IRQ_MASK_EN
    tbl[12] = '{1'b0, 2'd3, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 16'h0000, 1'b0, 0, 0, 8'h00, 1'b0};
`else
    tbl[12] = '{1'b0, 2'd3, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 16'h0000, 1'b1, 0, 0, 8'h00, 1'b0};
`endif
    tbl[13] = '{1'b1, 2'd0, 16'hFF5A, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 16'h0000, 1'b0, 1, 0, 8'h5A, 1'b0};

    // ---------------- reset ----------------
    rst = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_outputs", {pready, pslverr, prdata, transmit, rx_fifo_pop, tx_byte, irq}, '0);
    @(posedge clk); #1 rst = 1'b1;

    // ---------------- directed table ----------------
    exp_txb = 8'h00;
    for (int i = 0; i < 14; i++) begin
      tx_fifo_full = tbl[i].full; rx_fifo_empty = tbl[i].empty;
      uart_busy = tbl[i].busy; uart_irq = tbl[i].uirq; rx_byte = tbl[i].rxb;
      apb_xfer(tbl[i].wr, tbl[i].a, tbl[i].wd, 1'b0, 1'b0, r);
      check($sformatf("vec%0d_lat", i), r.lat, 2);
      check($sformatf("vec%0d_err", i), r.err, tbl[i].err);
      if (!tbl[i].wr) check($sformatf("vec%0d_rd", i), r.rd, tbl[i].rd);
      check($sformatf("vec%0d_ntx", i), r.ntx, tbl[i].ntx);
      check($sformatf("vec%0d_npop", i), r.npop, tbl[i].npop);
      if (tbl[i].ntx == 1) begin
        exp_txb = tbl[i].txb;
        check($sformatf("vec%0d_txb", i), r.txb, tbl[i].txb);
      end
      if (tbl[i].ntx + tbl[i].npop == 1) check($sformatf("vec%0d_strobe_cyc", i), r.scyc, 1);
      check($sformatf("vec%0d_tx_byte_hold", i), tx_byte, exp_txb);
      check($sformatf("vec%0d_irq", i), irq, MASK_EN ? 1'b0 : tbl[i].irq);
    end

    // ---------------- underflow set collides with CLEAR of rx_under ----------------
    tx_fifo_full = 1'b0; rx_fifo_empty = 1'b1; uart_busy = 1'b0; uart_irq = 1'b0;
    apb_xfer(1'b0, 2'd0, 16'h0000, 1'b1, 1'b0, r);
    check("collide_err", r.err, 1'b1);
    check("collide_npop", r.npop, 0);
    apb_xfer(1'b0, 2'd1, 16'h0000, 1'b0, 1'b0, r);
    check("collide_status", r.rd, 16'h0011);

    // ---------------- psel dropped after acceptance ----------------
    rx_fifo_empty = 1'b0;
    apb_xfer(1'b1, 2'd0, 16'h0033, 1'b0, 1'b1, r);
    check("drop_ntx", r.ntx, 1);
    check("drop_lat", r.lat, 2);
    check("drop_txb", tx_byte, 8'h33);

`ifdef UART_APB_IRQ_MASK_EN
    // ---------------- interrupt mask ----------------
    uart_irq = 1'b1;
    apb_xfer(1'b0, 2'd3, 16'h0000, 1'b0, 1'b0, r);
    check("mask_en_reset", r.rd, 16'h0000);
    check("mask_irq_off", irq, 1'b0);
    apb_xfer(1'b1, 2'd3, 16'h0001, 1'b0, 1'b0, r);
    check("mask_wr_err", r.err, 1'b0);
    check("mask_irq_on", irq, 1'b1);
    apb_xfer(1'b0, 2'd3, 16'h0000, 1'b0, 1'b0, r);
    check("mask_readback", r.rd, 16'h0001);
    uart_irq = 1'b0;
    repeat (2) @(negedge clk);
    check("mask_under_not_enabled", irq, 1'b0);
`endif

    // ---------------- reset during ACCESS ----------------
    tx_fifo_full = 1'b0; uart_irq = 1'b0;
    @(posedge clk); #1;
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 2'd0; pwdata = 16'h0077;
    @(posedge clk); #1 penable = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check("rst_access_no_tx", transmit, 1'b0);
    @(posedge clk); #1;
    rst = 1'b1; psel = 1'b0; penable = 1'b0;
    r.ntx = 0; r.lat = 0;
    repeat (3) begin
      @(negedge clk);
      if (transmit) r.ntx++;
      if (pready) r.lat++;
    end
    check("rst_access_tx_after", r.ntx, 0);
    check("rst_access_pready", r.lat, 0);
    check("rst_access_state", {tx_byte, irq, pslverr, prdata}, '0);

    // ---------------- randomized run against model ----------------
    m_drop = 1'b0; m_under = 1'b0; m_en = MASK_EN ? 3'b000 : 3'b111;
    exp_txb = 8'h00;
    for (int n = 0; n < 300; n++) begin
      wr = 1'($urandom_range(0, 1));
      a  = 2'($urandom_range(0, 3));
      wd = 16'($urandom);
      tx_fifo_full  = ($urandom_range(0, 3) == 0);
      rx_fifo_empty = ($urandom_range(0, 3) == 0);
      uart_busy     = 1'($urandom_range(0, 1));
      uart_irq      = ($urandom_range(0, 4) == 0);
      rx_byte       = 8'($urandom);
      e_rd = '0; e_err = 1'b0; e_tx = 0; e_pop = 0;
      case (a)
        2'd0: if (wr) begin
                if (tx_fifo_full) begin e_err = 1'b1; m_drop = 1'b1; end
                else begin e_tx = 1; exp_txb = wd[7:0]; end
              end else begin
                if (rx_fifo_empty) begin e_err = 1'b1; m_under = 1'b1; end
                else begin e_pop = 1; e_rd = {8'h00, rx_byte}; end
              end
        2'd1: if (wr) e_err = 1'b1;
              else e_rd = 16'(rx_fifo_empty + 2 * tx_fifo_full + 4 * uart_busy
                              + 8 * m_drop + 16 * m_under + 32 * uart_irq);
        2'd2: if (wr) begin
                if (wd[3]) m_drop = 1'b0;
                if (wd[4]) m_under = 1'b0;
              end
        default: if (MASK_EN) begin
                   if (wr) m_en = wd[2:0];
                   else e_rd = {13'h0, m_en};
                 end else e_err = 1'b1;
      endcase
      e_irq = (uart_irq & m_en[0]) | (m_drop & m_en[1]) | (m_under & m_en[2]);
      apb_xfer(wr, a, wd, 1'b0, 1'b0, r);
      check($sformatf("rnd%0d_lat", n), r.lat, 2);
      check($sformatf("rnd%0d_err", n), r.err, e_err);
      if (!wr) check($sformatf("rnd%0d_rd", n), r.rd, e_rd);
      check($sformatf("rnd%0d_ntx", n), r.ntx, e_tx);
      check($sformatf("rnd%0d_npop", n), r.npop, e_pop);
      check($sformatf("rnd%0d_tx_byte", n), tx_byte, exp_txb);
      check($sformatf("rnd%0d_irq", n), irq, e_irq);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
